// File: rtl/fifo_rd_drain.sv
// Read-side drain for a 2^AW-entry FIFO. It paces single-cycle rd strobes against
// a 2-entry valid/ready output buffer so that reads never underflow and words are never dropped.
module fifo_rd_drain #(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [AW-1:0] wrptr,
    input  logic [AW-1:0] rdptr,
    input  logic [DW-1:0] dout,
    output logic          rd,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [AW-1:0] fifo_level,
    output logic [1:0]    buf_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q;
    logic          rd_q;
    logic          inflight_q;
    logic [1:0]    lat_cnt_q;
    logic [AW-1:0] level_q;

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;

    logic          capture;
    logic          pop;
    logic          credit_ok;

    assign capture   = (state_q == WAIT) && (lat_cnt_q == 2'(RD_LAT));
    assign pop       = m_valid && m_ready;
    assign credit_ok = (3'(cnt_q) + 3'(inflight_q)) < 3'd2;

    assign rd         = rd_q;
    assign fifo_level = level_q;
    assign buf_cnt    = cnt_q;
    assign m_valid    = (cnt_q != 2'd0);
    assign m_data     = head_q;

    // Read sequencer. The decision uses the registered level, which already
    // reflects the rdptr advance from the previous read by the time IDLE is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            inflight_q <= 1'b0;
            lat_cnt_q  <= 2'd0;
            level_q    <= '0;
        end else begin
            level_q <= wrptr - rdptr;
            case (state_q)
                IDLE: begin
                    rd_q <= 1'b0;
                    if (en && (level_q != '0) && credit_ok) begin
                        state_q    <= ISSUE;
                        rd_q       <= 1'b1;
                        inflight_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q   <= WAIT;
                    rd_q      <= 1'b0;
                    lat_cnt_q <= 2'd1;
                end
                WAIT: begin
                    rd_q <= 1'b0;
                    if (capture) begin
                        state_q    <= IDLE;
                        inflight_q <= 1'b0;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry shift buffer: head drives m_data, tail only ever holds the second word.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({capture, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = dout;
                else               tail_d = dout;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) head_d = tail_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = dout;
                end else begin
                    head_d = tail_q;
                    tail_d = dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO model, scoreboard on the output stream,
// table of drain scenarios plus hand-written corner sequences.
module tb_fifo_rd_drain;

    logic       clk = 1'b0;
    logic       rst_n, en, m_ready;
    logic [3:0] wp, rp, ld_val;
    logic       ld;
    logic [7:0] dout_q;
    logic [7:0] mem [16];

    logic       rd, m_valid;
    logic [7:0] m_data;
    logic [3:0] fifo_level;
    logic [1:0] buf_cnt;

    int         n_chk = 0;
    int         n_fail = 0;
    int         rd_total = 0;
    bit         rd_prev = 1'b0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [3:0] start;
        int         n;
        bit         hold;
        int         exp_rd;
        int         exp_lvl;
        int         exp_buf;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    fifo_rd_drain #(.AW(4), .DW(8), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wrptr(wp), .rdptr(rp), .dout(dout_q),
        .rd(rd), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fifo_level(fifo_level), .buf_cnt(buf_cnt)
    );

    // FIFO read side with one cycle of read latency
    initial dout_q = 8'h00;
    always @(posedge clk) begin
        if (ld) rp <= ld_val;
        else if (rd === 1'b1) begin
            dout_q <= mem[rp];
            rp     <= rp + 4'd1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (rst_n) begin
            if (rd === 1'b1) begin
                rd_total++;
                check("underflow", 32'(rp == wp), 0);
                check("rd_b2b", 32'(rd_prev), 0);
            end
            rd_prev = (rd === 1'b1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("sb_extra_word", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(m_data), 32'(e));
                end
            end
        end else begin
            rd_prev = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int n);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = 8'($urandom_range(0, 255));
            mem[wp + 4'(i)] = v;
            exp_q.push_back(v);
        end
        wp = wp + 4'(n);
    endtask

    task automatic preload(input logic [3:0] s);
        ld = 1'b1; ld_val = s; wp = s;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s;
        bit  found;
        logic [7:0] w2;

        vecs[0] = '{4'd0,  9,  1'b0, 9,  0, 0};
        vecs[1] = '{4'd9,  5,  1'b1, 2,  3, 2};
        vecs[2] = '{4'd14, 4,  1'b0, 4,  0, 0};
        vecs[3] = '{4'd5,  15, 1'b0, 15, 0, 0};
        vecs[4] = '{4'd12, 3,  1'b1, 2,  1, 2};

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // reset with a non-empty FIFO
        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; ld = 1'b0; ld_val = 4'd0; wp = 4'd0;
        preload(4'd0);
        write_words(3);
        tick();
        check("rst_rd", 32'(rd), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_buf_cnt", 32'(buf_cnt), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_m_data", 32'(m_data), 0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (rd === 1'b1) begin found = 1'b1; break; end
        end
        check("rst_first_rd_2cyc", 32'(found), 1);
        repeat (15) tick();
        check("rst_drained", exp_q.size(), 0);
        check("rst_level_end", 32'(fifo_level), 0);

        // table of drain scenarios
        for (int v = 0; v < 5; v++) begin
            en = 1'b0;
            preload(vecs[v].start);
            m_ready = !vecs[v].hold;
            write_words(vecs[v].n);
            tick(); tick();
            check("tbl_level_pre", 32'(fifo_level), 32'(vecs[v].n));
            en = 1'b1;
            s = rd_total;
            repeat (vecs[v].n * 4 + 10) tick();
            check("tbl_rd_count", rd_total - s, vecs[v].exp_rd);
            check("tbl_level", 32'(fifo_level), vecs[v].exp_lvl);
            check("tbl_buf_cnt", 32'(buf_cnt), vecs[v].exp_buf);
            check("tbl_m_valid", 32'(m_valid), 32'(vecs[v].exp_buf != 0));
            if (vecs[v].hold) begin
                m_ready = 1'b1;
                repeat (25) tick();
            end
            check("tbl_drained", exp_q.size(), 0);
            check("tbl_level_end", 32'(fifo_level), 0);
            check("tbl_buf_end", 32'(buf_cnt), 0);
        end

        // capture and pop on the same edge at buf_cnt == 1
        en = 1'b0; m_ready = 1'b0;
        write_words(2);
        w2 = exp_q[1];
        tick();
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd === 1'b1 && buf_cnt == 2'd1) begin found = 1'b1; break; end
        end
        check("sim_second_rd", 32'(found), 1);
        tick();
        m_ready = 1'b1;
        tick();
        check("sim_buf_cnt", 32'(buf_cnt), 1);
        check("sim_head", 32'(m_data), 32'(w2));
        check("sim_m_valid", 32'(m_valid), 1);
        repeat (10) tick();
        check("sim_drained", exp_q.size(), 0);

        // en dropped during the rd cycle
        en = 1'b0; m_ready = 1'b1;
        write_words(3);
        tick();
        en = 1'b1;
        s = rd_total;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd === 1'b1) begin found = 1'b1; break; end
        end
        check("en0_rd_seen", 32'(found), 1);
        en = 1'b0;
        repeat (10) tick();
        check("en0_one_rd", rd_total - s, 1);
        check("en0_words_left", exp_q.size(), 2);
        check("en0_level", 32'(fifo_level), 2);
        en = 1'b1;
        repeat (15) tick();
        check("en0_drained", exp_q.size(), 0);

        // reset while a read is in WAIT
        en = 1'b0; m_ready = 1'b1;
        write_words(1);
        tick();
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd === 1'b1) begin found = 1'b1; break; end
        end
        check("rstw_rd_seen", 32'(found), 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("rstw_m_valid", 32'(m_valid), 0);
        check("rstw_buf_cnt", 32'(buf_cnt), 0);
        check("rstw_rd", 32'(rd), 0);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (6) tick();
        check("rstw_no_word", 32'(m_valid), 0);
        check("rstw_level", 32'(fifo_level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
